slave_port_ctrl: RTL and testbench

// Per-slave transaction sequencer placed after the round-robin request arbiter.

---
 rtl/slave_port_ctrl.sv | 139 +++++++++++++
 tb/tb_slave_port_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_ctrl.sv
// slave_port_ctrl
// Per-slave transaction sequencer that sits after the round-robin request arbiter.
// It accepts one granted beat (perm0/perm1 with addr/cmd/wdata) and drives it on the
// slave req/ack handshake. Completion and read data go back to the master that owns
// the transfer. busy holds off the arbiter while a transfer is in flight. A watchdog
// aborts the transfer with an error flag if the slave never acks.
//
// Ports
//   clk, reset          clock (rising edge) and synchronous active-high reset
//   perm0, perm1        grant pulses from the arbiter (master 0 wins a tie)
//   addr_in, cmd_in,    beat from the arbiter, valid in the grant cycle
//   wdata_in            (cmd: 1 = write, 0 = read)
//   busy                transfer in flight, arbiter must not grant this slave
//   s_req               request to the slave, held until s_ack
//   s_addr, s_cmd,      latched beat, stable while s_req is high
//   s_wdata
//   s_ack, s_rdata      slave acknowledge and read data (sampled only while requesting)
//   ack0, ack1          one-cycle completion pulse to the owning master
//   err0, err1          one-cycle timeout flag, coincident with the ack pulse
//   rdata_to            read data to the masters, valid only while an ack is high
module slave_port_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              perm0,
  input  logic              perm1,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              cmd_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_cmd,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata_to
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // TIMEOUT == 0 disables the watchdog entirely.
  localparam bit             WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              owner;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TO_W-1:0]   wd_cnt;

  logic accept, ack_take, to_fire;

  // Counter holds at all-ones instead of wrapping back to zero.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
    if (&c) return c;
    return c + TO_W'(1);
  endfunction

  assign accept   = (state == IDLE) && (perm0 || perm1);
  assign ack_take = (state == REQ) && s_ack;
  // An ack in the same cycle as the last allowed REQ cycle takes priority.
  assign to_fire  = (state == REQ) && !s_ack && WD_EN && (wd_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    s_req     = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    rdata_to  = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        busy  = 1'b1;
        s_req = 1'b1;
        if (ack_take || to_fire) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack0      = !owner;
        ack1      = owner;
        err0      = !owner && err_q;
        err1      = owner && err_q;
        rdata_to  = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_addr  <= '0;
      s_cmd   <= 1'b0;
      s_wdata <= '0;
      owner   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wd_cnt  <= '0;
    end else begin
      if (accept) begin
        s_addr  <= addr_in;
        s_cmd   <= cmd_in;
        s_wdata <= wdata_in;
        owner   <= !perm0;
        wd_cnt  <= '0;
      end
      if (ack_take) begin
        // Writes return zero so stale bus data never reaches the master.
        rdata_q <= s_cmd ? '0 : s_rdata;
        err_q   <= 1'b0;
      end else if (to_fire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (state == REQ) begin
        wd_cnt  <= sat_inc(wd_cnt);
      end
    end
  end

endmodule

// File: tb/tb_slave_port_ctrl.sv
module tb_slave_port_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          perm0 = 1'b0, perm1 = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          cmd_in = 1'b0;
  logic [DW-1:0] wdata_in = '0;
  logic          busy, s_req, s_cmd, ack0, ack1, err0, err1;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, rdata_to;
  logic          s_ack = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  slave_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk(clk), .reset(reset), .perm0(perm0), .perm1(perm1),
    .addr_in(addr_in), .cmd_in(cmd_in), .wdata_in(wdata_in),
    .busy(busy), .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata_to(rdata_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding transfer, described by how many
  // request cycles it has spent waiting and whether it is in its response cycle.
  bit          m_busy, m_inreq, m_resp, m_owner, m_err, m_cmd;
  int          m_reqcyc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_inreq <= 0; m_resp <= 0; m_owner <= 0; m_err <= 0;
      m_cmd <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_reqcyc <= 0;
    end else if (m_resp) begin
      m_resp <= 0;
      m_busy <= 0;
    end else if (m_inreq) begin
      if (s_ack) begin
        m_inreq <= 0; m_resp <= 1; m_err <= 0;
        m_rdata <= m_cmd ? '0 : s_rdata;
      end else if (TIMEOUT != 0 && m_reqcyc + 1 == TIMEOUT) begin
        m_inreq <= 0; m_resp <= 1; m_err <= 1; m_rdata <= '0;
      end else begin
        m_reqcyc <= m_reqcyc + 1;
      end
    end else if (perm0 || perm1) begin
      m_addr <= addr_in; m_cmd <= cmd_in; m_wdata <= wdata_in;
      m_owner <= !perm0; m_inreq <= 1; m_busy <= 1; m_reqcyc <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy",  busy,    m_busy);
      chk("m_s_req", s_req,   m_inreq);
      chk("m_addr",  s_addr,  m_addr);
      chk("m_cmd",   s_cmd,   m_cmd);
      chk("m_wdata", s_wdata, m_wdata);
      chk("m_ack0",  ack0,    m_resp && !m_owner);
      chk("m_ack1",  ack1,    m_resp && m_owner);
      chk("m_err0",  err0,    m_resp && !m_owner && m_err);
      chk("m_err1",  err1,    m_resp && m_owner && m_err);
      chk("m_rdata", rdata_to, m_resp ? m_rdata : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input bit p0, input bit p1, input logic [AW-1:0] a,
                       input bit c, input logic [DW-1:0] w);
    perm0 = p0; perm1 = p1; addr_in = a; cmd_in = c; wdata_in = w;
    tick();
    perm0 = 0; perm1 = 0; addr_in = '0; cmd_in = 0; wdata_in = '0;
  endtask

  task automatic ack_now(input logic [DW-1:0] rd);
    s_ack = 1; s_rdata = rd;
    tick();
    s_ack = 0; s_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    tick();
    chk_en = 1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_sreq", s_req, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_acks", {ack0, ack1, err0, err1}, 4'b0000);
    reset = 0;
    tick();

    // 1: write by master 0, ack two cycles after the request rises
    grant(1, 0, 32'h1000, 1, 32'hDEADBEEF);
    chk("t1_sreq", s_req, 1);
    tick(); tick();
    chk("t1_hold_addr", s_addr, 32'h1000);
    chk("t1_hold_wdata", s_wdata, 32'hDEADBEEF);
    ack_now(32'hFFFF0000);
    chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    chk("t1_err0", err0, 0);
    chk("t1_rdata", rdata_to, 0);
    chk("t1_sreq_low", s_req, 0);
    tick();
    chk("t1_ack0_once", ack0, 0);
    chk("t1_idle", busy, 0);

    // 2: read by master 1, acked in the first request cycle
    grant(0, 1, 32'h20, 0, '0);
    ack_now(32'h12345678);
    chk("t2_ack1", ack1, 1);
    chk("t2_rdata", rdata_to, 32'h12345678);
    chk("t2_busy_resp", busy, 1);
    tick();
    chk("t2_busy_low", busy, 0);
    chk("t2_rdata_clr", rdata_to, 0);

    // 3a: read that the slave never acks -> watchdog abort
    grant(1, 0, 32'h40, 0, '0);
    n = 0;
    while (s_req && n < 20) begin n++; tick(); end
    chk("t3_req_cycles", n, TIMEOUT);
    chk("t3_ack0", ack0, 1);
    chk("t3_err0", err0, 1);
    chk("t3_rdata", rdata_to, 0);
    tick();
    chk("t3_idle", busy, 0);

    // 3b: ack lands on the last allowed request cycle -> no error
    grant(1, 0, 32'h44, 0, '0);
    tick(); tick(); tick();
    ack_now(32'h0000A5A5);
    chk("t3b_ack0", ack0, 1);
    chk("t3b_err0", err0, 0);
    chk("t3b_rdata", rdata_to, 32'h0000A5A5);
    tick();

    // 4: simultaneous grants, then a stray grant during the request
    grant(1, 1, 32'h300, 1, 32'hCAFE0001);
    chk("t4_addr", s_addr, 32'h300);
    grant(0, 1, 32'h999, 0, 32'h1);
    chk("t4_addr_kept", s_addr, 32'h300);
    chk("t4_cmd_kept", s_cmd, 1);
    ack_now('0);
    chk("t4_ack0", ack0, 1);
    chk("t4_ack1", ack1, 0);
    tick();

    // 5: reset while requesting drops the transfer silently
    grant(1, 0, 32'h500, 0, '0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("t5_sreq", s_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_noack", {ack0, ack1}, 2'b00);
    chk("t5_addr_clr", s_addr, 0);
    tick();
    chk("t5_noack_later", {ack0, ack1}, 2'b00);
    grant(0, 1, 32'h55, 0, '0);
    ack_now(32'h00000055);
    chk("t5_ack1", ack1, 1);
    chk("t5_rdata", rdata_to, 32'h55);
    tick();

    // 6: back-to-back; a grant in the response cycle is ignored
    grant(1, 0, 32'h600, 1, 32'h66);
    ack_now('0);
    chk("t6_ack0", ack0, 1);
    grant(0, 1, 32'h777, 0, '0);
    chk("t6_resp_perm_ignored", busy, 0);
    chk("t6_addr_kept", s_addr, 32'h600);
    grant(0, 1, 32'h888, 0, '0);
    chk("t6_second_req", s_req, 1);
    chk("t6_second_addr", s_addr, 32'h888);
    ack_now(32'h00000888);
    chk("t6_ack1", ack1, 1);
    chk("t6_rdata", rdata_to, 32'h888);
    tick();
    chk("t6_idle", busy, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
